// File: rtl/fft_mem_pkg.sv
// fft_mem_pkg: constants and types shared by the FFT accelerator memory windows
package fft_mem_pkg;
    localparam logic [31:0] SAMPLE_BASE_ADDR = 32'h7000;
    localparam logic [31:0] MAG_BASE_ADDR = 32'h6000;
    localparam int FRAME_WORDS = 512;
    localparam logic [31:0] OOR_PATTERN = 32'hDEADBEEF;

    typedef struct packed {
        logic valid;
        logic [31:0] data;
    } resp_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/sample_buffer_slave_rd_resp_pipe.sv
// rd_resp_pipe: fixed-latency read response shift register; data holds when no response moves
module rd_resp_pipe
    import fft_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        retire
);
    resp_t stage [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0].valid <= in_valid;
            if (in_valid) stage[0].data <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i].valid <= stage[i-1].valid;
                if (stage[i-1].valid) stage[i].data <= stage[i-1].data;
            end
        end
    end

    assign out_valid = stage[LATENCY-1].valid;
    assign out_data = stage[LATENCY-1].data;

    // a response entering the output stage on the next edge
    generate
        if (LATENCY == 1) begin : g_l1
            assign retire = in_valid;
        end else begin : g_ln
            assign retire = stage[LATENCY-2].valid;
        end
    endgenerate
endmodule

// File: rtl/sample_buffer_slave.sv
// sample_buffer_slave: Avalon-MM slave holding one sample frame in on-chip RAM
module sample_buffer_slave
    import fft_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SAMPLE_BASE_ADDR,
    parameter int DEPTH = FRAME_WORDS,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        frame_done,
    output logic [15:0] oor_count,
    output logic        proto_err
);
    localparam int IW = idx_width(DEPTH);
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic [31:0] mem [DEPTH];
    logic [31:0] off;
    logic [31:0] rd_word;
    logic [IW-1:0] widx;
    logic [PW-1:0] pending;
    logic in_range, wr_acc, rd_acc, retire;

    assign off = avs_address - BASE_ADDR;
    assign in_range = (avs_address >= BASE_ADDR) && (off < 32'(4 * DEPTH));
    assign widx = off[IW+1:2];
    assign avs_waitrequest = avs_read && (pending == PW'(MAX_PENDING));
    assign wr_acc = avs_write && !rst;
    assign rd_acc = avs_read && !avs_waitrequest && !avs_write && !rst;
    assign rd_word = in_range ? mem[widx] : OOR_PATTERN;

    always_ff @(posedge clk) begin
        if (wr_acc && in_range)
            for (int b = 0; b < 4; b++)
                if (avs_byteenable[b]) mem[widx][8*b +: 8] <= avs_writedata[8*b +: 8];
    end

    rd_resp_pipe #(.LATENCY(READ_LATENCY)) u_pipe (
        .clk(clk),
        .rst(rst),
        .in_valid(rd_acc),
        .in_data(rd_word),
        .out_valid(avs_readdatavalid),
        .out_data(avs_readdata),
        .retire(retire)
    );

    // pending drops as a response reaches the output so back-to-back reads never stall
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            frame_done <= 1'b0;
            oor_count <= '0;
            proto_err <= 1'b0;
        end else begin
            pending <= pending + PW'(rd_acc) - PW'(retire);
            frame_done <= wr_acc && in_range && (widx == IW'(DEPTH - 1));
            if ((wr_acc || rd_acc) && !in_range && oor_count != 16'hFFFF) oor_count <= oor_count + 16'd1;
            if (avs_read && avs_write) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sample_buffer_slave.sv
// tb_sample_buffer_slave: randomized and directed checks against a queue-based behavioural model
module tb_sample_buffer_slave;
    localparam logic [31:0] BASE = 32'h7000;
    localparam int L = 2;
    localparam int MP = 2;
    localparam int N = 512;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] avs_address, avs_writedata;
    logic avs_read, avs_write;
    logic [3:0] avs_byteenable;
    logic avs_waitrequest, avs_readdatavalid, frame_done, proto_err;
    logic [31:0] avs_readdata;
    logic [15:0] oor_count;
    logic u1_waitrequest, u1_readdatavalid, u1_frame_done, u1_proto_err;
    logic [31:0] u1_readdata;
    logic [15:0] u1_oor_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sample_buffer_slave dut (
        .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .frame_done(frame_done),
        .oor_count(oor_count), .proto_err(proto_err)
    );

    sample_buffer_slave #(.MAX_PENDING(1)) u1 (
        .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(u1_waitrequest), .avs_readdata(u1_readdata),
        .avs_readdatavalid(u1_readdatavalid), .frame_done(u1_frame_done),
        .oor_count(u1_oor_count), .proto_err(u1_proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        @(negedge clk);
        rst = 1'b0;
        avs_read = r;
        avs_write = w;
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Behavioural model: memory array, queue of outstanding reads tagged with acceptance cycle
    typedef struct {
        int c;
        logic [31:0] d;
    } rsp_t;
    rsp_t q[$];
    logic [31:0] m [N];
    logic [31:0] held;
    logic fd, proto;
    logic [15:0] oor;
    bit armed = 0;
    int t = 0;

    always @(negedge clk) begin : cmp
        int pend, idx;
        logic ew, erdv, inr, racc;
        logic [31:0] ed;
        #2;
        pend = 0;
        foreach (q[i]) if (q[i].c + L > t) pend++;
        ew = avs_read && (pend == MP);
        erdv = (q.size() > 0) && (q[0].c + L == t);
        ed = erdv ? q[0].d : held;
        if (armed) begin
            chk("waitrequest", avs_waitrequest, ew);
            chk("readdatavalid", avs_readdatavalid, erdv);
            chk("readdata", avs_readdata, ed);
            chk("frame_done", frame_done, fd);
            chk("oor_count", oor_count, oor);
            chk("proto_err", proto_err, proto);
        end
        if (erdv) begin
            held = ed;
            void'(q.pop_front());
        end
        if (rst) begin
            q.delete();
            held = 32'h0;
            fd = 1'b0;
            oor = 16'h0;
            proto = 1'b0;
            armed = 1;
        end else begin
            inr = (avs_address >= BASE) && (avs_address < BASE + 32'd4 * N);
            idx = inr ? int'((avs_address - BASE) >> 2) : 0;
            racc = avs_read && !ew && !avs_write;
            fd = avs_write && inr && (idx == N - 1);
            if (avs_write && inr)
                for (int b = 0; b < 4; b++)
                    if (avs_byteenable[b]) m[idx][8*b +: 8] = avs_writedata[8*b +: 8];
            if (racc) q.push_back('{t, inr ? m[idx] : 32'hDEADBEEF});
            if ((avs_write || racc) && !inr && oor != 16'hFFFF) oor = oor + 16'd1;
            if (avs_read && avs_write) proto = 1'b1;
        end
        t++;
    end

    // MAX_PENDING=1 instance: responses must arrive in order, exactly two cycles apart
    bit mp1_on = 0;
    int mp1_j = 0;
    int mp1_last = 0;
    int c1 = 0;
    always @(negedge clk) begin
        #2;
        if (mp1_on && u1_readdatavalid) begin
            chk("mp1_data", u1_readdata, 32'h11 + 32'(mp1_j));
            if (mp1_j > 0) chk("mp1_spacing", 32'(c1 - mp1_last), 32'd2);
            mp1_last = c1;
            mp1_j++;
        end
        c1++;
    end

    initial begin
        int wc, fdc, seen, k, n, r;
        logic [31:0] a;
        rst = 1'b1;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_address = 32'h0;
        avs_writedata = 32'h0;
        avs_byteenable = 4'h0;
        repeat (3) @(negedge clk);
        idle(); #1;
        chk("rst_rdv", avs_readdatavalid, 0);
        chk("rst_readdata", avs_readdata, 0);
        chk("rst_oor", oor_count, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wait", avs_waitrequest, 0);

        fdc = 0;
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 1'b1, BASE + 32'(4 * i), 32'h11 + 32'(i), 4'hF); #1;
            fdc += int'(frame_done);
        end
        idle(); #1;
        chk("frame_done_pulse", frame_done, 1);
        chk("frame_done_early", fdc, 0);
        idle(); #1;
        chk("frame_done_single", frame_done, 0);
        chk("oor_after_frame", oor_count, 0);

        wc = 0;
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0); #1;
            wc += int'(avs_waitrequest);
            if (i == 2) begin
                chk("first_read_rdv", avs_readdatavalid, 1);
                chk("first_read_data", avs_readdata, 32'h11);
            end
        end
        idle(); idle(); #1;
        chk("seq_read_wait_count", wc, 0);
        chk("last_read_data", avs_readdata, 32'h210);
        idle(); idle();

        mp1_on = 1;
        k = 0;
        n = 0;
        while (k < N && n < 2000) begin
            cyc(1'b1, 1'b0, BASE + 32'(4 * k), 32'h0, 4'h0); #1;
            chk("mp1_wait", u1_waitrequest, 32'(n % 2));
            if (!u1_waitrequest) k++;
            n++;
        end
        chk("mp1_reads_done", k, N);
        idle(); idle(); idle();
        chk("mp1_resp_count", mp1_j, N);
        mp1_on = 0;

        cyc(1'b0, 1'b1, BASE + 4, 32'hAABBCCDD, 4'hF);
        cyc(1'b0, 1'b1, BASE + 4, 32'h00001100, 4'b0010);
        cyc(1'b1, 1'b0, BASE + 4, 32'h0, 4'h0);
        idle(); idle(); #1;
        chk("be_rdv", avs_readdatavalid, 1);
        chk("be_merge", avs_readdata, 32'hAABB11DD);

        cyc(1'b1, 1'b0, 32'h8000, 32'h0, 4'h0);
        cyc(1'b0, 1'b1, 32'h6FFC, 32'h5555AAAA, 4'hF);
        idle(); #1;
        chk("oor_rdv", avs_readdatavalid, 1);
        chk("oor_pattern", avs_readdata, 32'hDEADBEEF);
        chk("oor_count2", oor_count, 2);
        cyc(1'b1, 1'b0, BASE, 32'h0, 4'h0);
        idle(); idle(); #1;
        chk("ram_word0_unchanged", avs_readdata, 32'h11);
        cyc(1'b1, 1'b0, 32'h7800, 32'h0, 4'h0);
        idle(); idle(); #1;
        chk("edge_oor_pattern", avs_readdata, 32'hDEADBEEF);
        chk("edge_oor_count", oor_count, 3);

        cyc(1'b1, 1'b0, BASE, 32'h0, 4'h0);
        cyc(1'b1, 1'b0, BASE + 4, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        avs_read = 1'b0;
        avs_write = 1'b0;
        seen = 0;
        repeat (4) begin
            idle(); #1;
            seen += int'(avs_readdatavalid);
        end
        chk("no_rdv_after_rst", seen, 0);
        cyc(1'b1, 1'b0, BASE + 8, 32'h0, 4'h0); #1;
        chk("wait_after_rst", avs_waitrequest, 0);
        idle(); idle(); idle();

        cyc(1'b1, 1'b1, BASE + 8, 32'h12345678, 4'hF);
        idle(); #1;
        chk("proto_set", proto_err, 1);
        idle(); #1;
        chk("dropped_read_no_rdv", avs_readdatavalid, 0);
        cyc(1'b1, 1'b0, BASE + 8, 32'h0, 4'h0);
        idle(); idle(); #1;
        chk("rw_write_committed", avs_readdata, 32'h12345678);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            a = BASE - 32'd16 + 32'($urandom_range(0, 2079));
            if (r < 1) begin
                @(negedge clk);
                rst = 1'b1;
                avs_read = 1'b0;
                avs_write = 1'b0;
            end else begin
                cyc(r < 50, r >= 47 && r < 90, a, $urandom, 4'($urandom_range(0, 15)));
            end
        end

        for (int i = 0; i < 65540; i++) cyc(1'b0, 1'b1, 32'h9000, 32'h0, 4'hF);
        idle(); #1;
        chk("oor_saturated", oor_count, 16'hFFFF);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sample_buffer_slave.md
Name: sample_buffer_slave

Overview:
Avalon-MM slave (responder) holding one 512-word sample/magnitude frame in on-chip RAM, addressed by byte address from BASE_ADDR. It sits on the far end of the FFT accelerator's master ports, standing in for the SDRAM window at 0x7000/0x6000. It answers pipelined reads with fixed-latency readdatavalid and throttles the master with waitrequest. It flags frame completion and out-of-range traffic to the CPU side.

Parameters:
BASE_ADDR, 32'h7000, byte address of word 0
DEPTH, 512, number of 32-bit words (power of two)
READ_LATENCY, 2, cycles from read acceptance to readdatavalid (>=1)
MAX_PENDING, 2, max reads in flight before waitrequest stalls reads (1..READ_LATENCY)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
avs_address  in  32  byte address
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  32  write data
avs_byteenable  in  4  per-byte write enable
avs_waitrequest  out  1  1 = request not accepted this cycle
avs_readdata  out  32  read response data
avs_readdatavalid  out  1  response valid strobe
frame_done  out  1  one-cycle pulse after write to last word
oor_count  out  16  saturating count of out-of-range accesses
proto_err  out  1  sticky: read and write asserted together

Behaviour:
- Reset (rst=1 at posedge): avs_readdatavalid=0, avs_readdata=0, frame_done=0, oor_count=0, proto_err=0, pending=0, response pipe cleared. RAM contents are not cleared.
- Reset mid-operation: all in-flight reads are discarded. No readdatavalid may appear for a read accepted before reset.
- In range: BASE_ADDR <= addr < BASE_ADDR+4*DEPTH. Word index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored.
- Acceptance: a request is accepted in a cycle where it is asserted and avs_waitrequest=0.
- avs_waitrequest = avs_read & (pending == MAX_PENDING), from the registered pending count. Writes are never stalled.
- Write: commits on the accepting edge, only for bytes with byteenable=1. byteenable=0000 is accepted with no change.
- Read: RAM is sampled on the accepting edge. Data appears with avs_readdatavalid=1 exactly READ_LATENCY cycles later.
- Responses are in order and back-to-back capable: one read per cycle when MAX_PENDING=READ_LATENCY.
- A read accepted the cycle after a write to the same word returns the new data.
- pending: +1 on accepted read, -1 on readdatavalid; unchanged when both occur in the same cycle.
- Out-of-range read: accepted, returns 32'hDEADBEEF at normal latency, oor_count+1.
- Out-of-range write: accepted and dropped, oor_count+1.
- oor_count saturates at 16'hFFFF.
- avs_read & avs_write in the same cycle: the write is processed, the read is dropped (no response), proto_err is set until reset. avs_waitrequest in that cycle follows the read formula.
- frame_done: single-cycle pulse in the cycle after an accepted in-range write to word DEPTH-1. Fires on every such write.
- avs_readdata is held at its last value when avs_readdatavalid=0.

Decomposition:
- Shared package fft_mem_pkg: BASE_ADDR defaults (32'h7000, 32'h6000), FRAME_WORDS=512, OOR_PATTERN=32'hDEADBEEF, word-index width function.
- Sub-module rd_resp_pipe: READ_LATENCY-deep shift register of {valid, data}, synchronously cleared by rst.
- The RAM is an inferred single-port array in the top module.

Test Plan:
- Write 0x00000011..0x00000210 to 0x7000..0x77FC, back-to-back -> frame_done pulses once, one cycle after the write to 0x77FC; oor_count=0.
- Read 0x7000..0x77FC continuously with READ_LATENCY=2, MAX_PENDING=2 -> no waitrequest; readdatavalid each cycle from cycle 2; data matches in order.
- MAX_PENDING=1, reads held asserted -> waitrequest alternates; one response every 2 cycles; all 512 values correct.
- Write 0xAABBCCDD to 0x7004, then byteenable=0010 with 0x00001100 -> read returns 0xAABB11DD.
- Read 0x8000, write 0x6FFC -> read returns 0xDEADBEEF after 2 cycles; oor_count=2; RAM unchanged.
- Assert rst one cycle after two accepted reads -> no readdatavalid follows; pending=0. Read+write together -> write commits, no response, proto_err=1.
